burst_addr_rx: RTL

- Receiving end of the serial burst-control interface, on the memory/STP side of the serial link.
- Deserialises the serial burst-length and start-address stream.
- Then issues one parallel address per beat to the MRAM access logic, using a valid/ready handshake.
- Single-transfer mode issues exactly one address; burst mode issues len+1 incrementing addresses.

---
 rtl/burst_addr_rx.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/burst_addr_rx.sv
// Purpose : serial burst-control receiver; deserialises [len][addr] and issues one address per beat.
// Latency : addr_valid rises 1 cycle after the last serial bit (address, or parity bit when enabled).
// Backpr. : addr_out/addr_valid hold while addr_ready=0; serial input stalls freely on ser_valid=0.
//
// Ports:
//   clk, rst (async, active-low)
//   burst_en   - enable; dropping it outside IDLE aborts (err pulse, no done)
//   mode_sel   - 0 single transfer, 1 burst; captured when leaving IDLE
//   ser_valid  - qualifies ser_in
//   ser_in     - serial stream, MSB first: [len (burst only)][address][parity (option)]
//   addr_out   - current beat address
//   addr_valid - addr_out valid; beat accepted on addr_valid && addr_ready
//   addr_ready - downstream ready
//   busy       - state != IDLE (registered)
//   done       - one-cycle pulse after the last beat is accepted
//   err        - one-cycle pulse on abort or parity mismatch
//
// Optional feature macro: BURST_ADDR_RX_PARITY_EN
//   When defined, one even-parity bit follows the address and is checked
//   before any beat is issued. A mismatch pulses err and still ends in DONE.
module burst_addr_rx #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              burst_en,
  input  logic              mode_sel,
  input  logic              ser_valid,
  input  logic              ser_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int MAX_W = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_LEN  = 3'd1,
    RX_ADDR = 3'd2,
`ifdef BURST_ADDR_RX_PARITY_EN
    RX_PAR  = 3'd3,
`endif
    ISSUE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [LEN_W-1:0]   len_q, len_d;
  // Only the first ADDR_W-1 address bits need storing; the last bit is
  // taken straight from ser_in on the edge that completes the address.
  logic [ADDR_W-2:0]  sr_q, sr_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]  addr_out_q, addr_out_d;
  logic               addr_valid_q, addr_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
`ifdef BURST_ADDR_RX_PARITY_EN
  logic               par_q, par_d;   // running XOR of every received bit
`endif

  logic               abort;
  logic               load_issue;
  logic [ADDR_W-1:0]  load_addr;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    len_d        = len_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    addr_out_d   = addr_out_q;
    addr_valid_d = addr_valid_q;
    err_d        = 1'b0;
    abort        = 1'b0;
    load_issue   = 1'b0;
    load_addr    = addr_out_q;
`ifdef BURST_ADDR_RX_PARITY_EN
    par_d        = par_q;
`endif

    case (state_q)
      IDLE: begin
        // Any leftovers from an aborted transfer are discarded here.
        bit_cnt_d = '0;
        len_d     = '0;
        sr_d      = '0;
`ifdef BURST_ADDR_RX_PARITY_EN
        par_d     = 1'b0;
`endif
        if (burst_en) begin
          mode_d  = mode_sel;
          state_d = mode_sel ? RX_LEN : RX_ADDR;
        end
      end

      RX_LEN: begin
        if (!burst_en) begin
          abort = 1'b1;
        end else if (ser_valid) begin
          len_d = {len_q[LEN_W-2:0], ser_in};
`ifdef BURST_ADDR_RX_PARITY_EN
          par_d = par_q ^ ser_in;
`endif
          if (bit_cnt_q == CNT_W'(LEN_W - 1)) begin
            bit_cnt_d = '0;
            state_d   = RX_ADDR;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

      RX_ADDR: begin
        if (!burst_en) begin
          abort = 1'b1;
        end else if (ser_valid) begin
          sr_d = {sr_q[ADDR_W-3:0], ser_in};
`ifdef BURST_ADDR_RX_PARITY_EN
          par_d = par_q ^ ser_in;
`endif
          if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
            bit_cnt_d = '0;
`ifdef BURST_ADDR_RX_PARITY_EN
            // Park the address on addr_out (valid still low) until the
            // parity bit has been checked.
            addr_out_d = {sr_q, ser_in};
            state_d    = RX_PAR;
`else
            load_issue = 1'b1;
            load_addr  = {sr_q, ser_in};
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end

`ifdef BURST_ADDR_RX_PARITY_EN
      RX_PAR: begin
        if (!burst_en) begin
          abort = 1'b1;
        end else if (ser_valid) begin
          // Even parity: all data bits plus the parity bit XOR to zero.
          if ((par_q ^ ser_in) == 1'b0) begin
            load_issue = 1'b1;
            load_addr  = addr_out_q;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
`endif

      ISSUE: begin
        // Abort wins over a handshake on the same edge.
        if (!burst_en) begin
          abort = 1'b1;
        end else if (addr_valid_q && addr_ready) begin
          if (beat_cnt_q != '0) begin
            addr_out_d = addr_out_q + ADDR_W'(1);
            beat_cnt_d = beat_cnt_q - LEN_W'(1);
          end else begin
            addr_valid_d = 1'b0;
            state_d      = DONE;
          end
        end
      end

      DONE: begin
        if (!burst_en) begin
          abort = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_issue) begin
      addr_out_d   = load_addr;
      addr_valid_d = 1'b1;
      // len is cleared in IDLE, but single mode forces one beat regardless.
      beat_cnt_d   = mode_q ? len_q : '0;
      state_d      = ISSUE;
    end

    if (abort) begin
      state_d      = IDLE;
      addr_valid_d = 1'b0;
      bit_cnt_d    = '0;
      err_d        = 1'b1;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      len_q        <= '0;
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      addr_out_q   <= '0;
      addr_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef BURST_ADDR_RX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      len_q        <= len_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      addr_out_q   <= addr_out_d;
      addr_valid_q <= addr_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
`ifdef BURST_ADDR_RX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  assign addr_out   = addr_out_q;
  assign addr_valid = addr_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
